// File: rtl/melody_player.sv
// Note-RAM driven piezo player: fetches one entry per note, then generates a
// volume-scaled active-low square wave for the note's beats with a silent tail.
module melody_player #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BEAT_TICKS = 15_000_000,
  parameter int DEPTH      = 64,
  parameter int AW         = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW:0]   song_len,
  input  logic          loop_en,
  input  logic [2:0]    volume,
  input  logic          start,
  input  logic          stop,
  output logic          pwm,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] note_idx,
  output logic [1:0]    dbg_state
);

  localparam int P1  = CLK_FREQ / 523;
  localparam int P2  = CLK_FREQ / 587;
  localparam int P3  = CLK_FREQ / 659;
  localparam int P4  = CLK_FREQ / 698;
  localparam int P5  = CLK_FREQ / 784;
  localparam int P6  = CLK_FREQ / 880;
  localparam int P7  = CLK_FREQ / 988;
  localparam int PW  = $clog2(P1 + 1);
  localparam int DW  = $clog2(8 * BEAT_TICKS + 1);
  localparam int GAP = BEAT_TICKS / 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_PLAY  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [7:0]    mem [DEPTH];

  logic [1:0]    state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [7:0]    entry_q, entry_d;
  logic [DW-1:0] dur_q, dur_d;
  logic [PW-1:0] per_q, per_d;
  logic          pwm_q, pwm_d;

  logic [2:0]    pitch;
  logic [1:0]    oct;
  logic [PW-1:0] base;
  logic [PW-1:0] period;
  logic [PW-1:0] low_len;
  logic [DW-1:0] dur_len;
  logic          note_end;
  logic          last_note;

  // RAM is deliberately left out of reset so a loaded song survives rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign pitch = entry_q[7:5];
  assign oct   = entry_q[4:3];

  always_comb begin
    base = PW'(P1);
    case (pitch)
      3'd2:    base = PW'(P2);
      3'd3:    base = PW'(P3);
      3'd4:    base = PW'(P4);
      3'd5:    base = PW'(P5);
      3'd6:    base = PW'(P6);
      3'd7:    base = PW'(P7);
      default: base = PW'(P1);
    endcase
  end

  assign period    = base >> oct;
  assign low_len   = (volume == 3'd0) ? '0 : (period >> (4'd8 - {1'b0, volume}));
  assign dur_len   = DW'({1'b0, entry_q[2:0]} + 4'd1) * DW'(BEAT_TICKS);
  assign note_end  = (dur_q == dur_len - DW'(1));
  assign last_note = ({1'b0, idx_q} == len_q - (AW+1)'(1));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    entry_d = entry_q;
    dur_d   = dur_q;
    per_d   = per_q;
    case (state_q)
      S_IDLE: begin
        if (start && !stop && song_len != '0) begin
          len_d   = song_len;
          idx_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        entry_d = mem[idx_q];
        dur_d   = '0;
        per_d   = '0;
        state_d = S_PLAY;
      end
      S_PLAY: begin
        dur_d = dur_q + DW'(1);
        per_d = (per_q >= period - PW'(1)) ? '0 : per_q + PW'(1);
        if (note_end) begin
          if (last_note && loop_en) begin
            idx_d   = '0;
            state_d = S_FETCH;
          end else if (last_note) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (stop && state_q != S_IDLE) state_d = S_IDLE;
  end

  // stop forces the pin high on the same edge that drops the FSM to IDLE.
  always_comb begin
    pwm_d = !(state_q == S_PLAY && !stop && pitch != 3'd0 && volume != 3'd0 &&
              dur_q < dur_len - DW'(GAP) && per_q < low_len);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      entry_q <= '0;
      dur_q   <= '0;
      per_q   <= '0;
      pwm_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      entry_q <= entry_d;
      dur_q   <= dur_d;
      per_q   <= per_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm       = pwm_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign note_idx  = idx_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_melody_player.sv
// Directed bench for melody_player with small clock/beat parameters:
// P[DO]=1912, P[MI]=1517, beat=4000 clocks, gap=1000 clocks.
module tb_melody_player;
  localparam int AW   = 6;
  localparam int NMAX = 20200;
  localparam int GAPC = 1000;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [AW:0]   song_len;
  logic          loop_en;
  logic [2:0]    volume;
  logic          start;
  logic          stop;
  logic          pwm;
  logic          busy;
  logic          done;
  logic [AW-1:0] note_idx;
  logic [1:0]    dbg_state;

  int errors = 0;
  int checks = 0;

  logic          pwm_a  [0:NMAX];
  logic          busy_a [0:NMAX];
  logic          done_a [0:NMAX];
  logic [AW-1:0] idx_a  [0:NMAX];

  int            wr_cycle = -1;
  logic [AW-1:0] wr_a;
  logic [7:0]    wr_d;

  melody_player #(
    .CLK_FREQ  (1_000_000),
    .BEAT_TICKS(4000),
    .DEPTH     (64),
    .AW        (AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .song_len (song_len),
    .loop_en  (loop_en),
    .volume   (volume),
    .start    (start),
    .stop     (stop),
    .pwm      (pwm),
    .busy     (busy),
    .done     (done),
    .note_idx (note_idx),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic write_entry(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // start is captured on the next posedge; cycle 1 is the cycle after it.
  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic watch(input int n);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      pwm_a[c]  = pwm;
      busy_a[c] = busy;
      done_a[c] = done;
      idx_a[c]  = note_idx;
      if (c == wr_cycle) begin
        wr_en = 1'b1; wr_addr = wr_a; wr_data = wr_d;
      end else begin
        wr_en = 1'b0;
      end
    end
    wr_en = 1'b0;
  endtask

  // Reference waveform of a single note starting at cycle 1 (FETCH).
  // Duration count k runs in cycle k+2; the registered pin shows it at k+3.
  function automatic logic model_pwm(input int c, input int per, input int low, input int dlen);
    int k;
    k = c - 3;
    if (k < 0 || k >= dlen - GAPC) return 1'b1;
    return ((k % per) < low) ? 1'b0 : 1'b1;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    song_len = '0; loop_en = 1'b0; volume = 3'd0; start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (pwm !== 1'b1) begin errors++; $display("FAIL reset_pwm: got %b expected 1", pwm); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (note_idx !== '0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", note_idx); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_note();
    int mism, lows, first_bad, dcount;
    write_entry(0, 8'h20);
    volume = 3'd7; song_len = 7'd1; loop_en = 1'b0;
    do_start();
    watch(4010);
    mism = 0; lows = 0; first_bad = -1; dcount = 0;
    for (int c = 1; c <= 4010; c++) begin
      if (pwm_a[c] !== model_pwm(c, 1912, 956, 4000)) begin
        mism++;
        if (first_bad < 0) first_bad = c;
      end
      if (pwm_a[c] === 1'b0) lows++;
      if (done_a[c] === 1'b1) dcount++;
    end
    checks++; if (mism != 0) begin errors++; $display("FAIL do_wave: got %0d bad cycles (first %0d) expected 0", mism, first_bad); end
    checks++; if (lows != 1912) begin errors++; $display("FAIL do_low_count: got %0d expected 1912", lows); end
    checks++; if (pwm_a[2] !== 1'b1 || pwm_a[3] !== 1'b0) begin errors++; $display("FAIL do_latency: got %b%b expected 10", pwm_a[2], pwm_a[3]); end
    checks++; if (dcount != 1 || done_a[4002] !== 1'b1) begin errors++; $display("FAIL do_done_pulse: got count %0d at4002 %b expected 1 1", dcount, done_a[4002]); end
    checks++; if (busy_a[4001] !== 1'b1 || busy_a[4003] !== 1'b0) begin errors++; $display("FAIL do_busy_fall: got %b%b expected 10", busy_a[4001], busy_a[4003]); end
  endtask

  task automatic test_octave_volume();
    int mism, lows, first_bad;
    write_entry(0, 8'h71);
    volume = 3'd4; song_len = 7'd1;
    do_start();
    watch(8010);
    mism = 0; lows = 0; first_bad = -1;
    for (int c = 1; c <= 8010; c++) begin
      if (pwm_a[c] !== model_pwm(c, 379, 23, 8000)) begin
        mism++;
        if (first_bad < 0) first_bad = c;
      end
      if (pwm_a[c] === 1'b0) lows++;
    end
    checks++; if (mism != 0) begin errors++; $display("FAIL mi_wave: got %0d bad cycles (first %0d) expected 0", mism, first_bad); end
    checks++; if (lows != 437) begin errors++; $display("FAIL mi_low_count: got %0d expected 437", lows); end
    checks++; if (done_a[8002] !== 1'b1 || done_a[8001] !== 1'b0) begin errors++; $display("FAIL mi_done: got %b%b expected 01", done_a[8001], done_a[8002]); end
  endtask

  task automatic test_rest();
    int highs;
    write_entry(0, 8'h20);
    write_entry(1, 8'h02);
    write_entry(2, 8'h20);
    volume = 3'd7; song_len = 7'd3;
    do_start();
    watch(20010);
    highs = 0;
    for (int c = 4002; c <= 16004; c++) if (pwm_a[c] === 1'b1) highs++;
    checks++; if (highs != 12003) begin errors++; $display("FAIL rest_silent: got %0d high cycles expected 12003", highs); end
    checks++; if (pwm_a[16005] !== 1'b0) begin errors++; $display("FAIL rest_next_note: got %b expected 0", pwm_a[16005]); end
    checks++; if (idx_a[2000] !== 6'd0) begin errors++; $display("FAIL rest_idx0: got %0d expected 0", idx_a[2000]); end
    checks++; if (idx_a[8000] !== 6'd1) begin errors++; $display("FAIL rest_idx1: got %0d expected 1", idx_a[8000]); end
    checks++; if (idx_a[18000] !== 6'd2) begin errors++; $display("FAIL rest_idx2: got %0d expected 2", idx_a[18000]); end
    checks++; if (done_a[20004] !== 1'b1) begin errors++; $display("FAIL rest_done: got %b expected 1", done_a[20004]); end
  endtask

  task automatic test_loop_stop();
    logic [AW-1:0] exp_seq [4];
    int            at      [4];
    int            dcount, highs;
    exp_seq = '{6'd0, 6'd1, 6'd0, 6'd1};
    at      = '{2000, 6000, 10000, 14000};
    write_entry(0, 8'h20);
    write_entry(1, 8'h20);
    volume = 3'd7; song_len = 7'd2; loop_en = 1'b1;
    // Entry 1 becomes a rest while entry 0 is still sounding.
    wr_cycle = 100; wr_a = 6'd1; wr_d = 8'h00;
    do_start();
    watch(16100);
    wr_cycle = -1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (idx_a[at[i]] !== exp_seq[i]) begin
        errors++; $display("FAIL loop_idx_%0d: got %0d expected %0d", at[i], idx_a[at[i]], exp_seq[i]);
      end
    end
    dcount = 0; highs = 0;
    for (int c = 1; c <= 16100; c++) if (done_a[c] === 1'b1) dcount++;
    for (int c = 4003; c <= 8004; c++) if (pwm_a[c] === 1'b1) highs++;
    checks++; if (dcount != 0) begin errors++; $display("FAIL loop_no_done: got %0d pulses expected 0", dcount); end
    checks++; if (highs != 4002) begin errors++; $display("FAIL rewrite_entry1: got %0d high cycles expected 4002", highs); end
    checks++; if (pwm_a[8005] !== 1'b0) begin errors++; $display("FAIL loop_wrap_tone: got %b expected 0", pwm_a[8005]); end
    checks++; if (pwm_a[16100] !== 1'b0) begin errors++; $display("FAIL stop_pre_low: got %b expected 0", pwm_a[16100]); end
    stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    @(negedge clk);
    checks++; if (pwm !== 1'b1) begin errors++; $display("FAIL stop_pwm: got %b expected 1", pwm); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL stop_done: got %b expected 0", done); end
    loop_en = 1'b0;
  endtask

  task automatic test_ignored_starts();
    int bcount;
    song_len = '0;
    do_start();
    watch(10);
    bcount = 0;
    for (int c = 1; c <= 10; c++) if (busy_a[c] === 1'b1) bcount++;
    checks++; if (bcount != 0) begin errors++; $display("FAIL len0_ignored: got %0d busy cycles expected 0", bcount); end
    song_len = 7'd1;
    start = 1'b1; stop = 1'b1;
    @(posedge clk);
    #1 begin start = 1'b0; stop = 1'b0; end
    watch(10);
    bcount = 0;
    for (int c = 1; c <= 10; c++) if (busy_a[c] === 1'b1) bcount++;
    checks++; if (bcount != 0) begin errors++; $display("FAIL start_stop_same: got %0d busy cycles expected 0", bcount); end
  endtask

  task automatic test_reset_mid();
    int bcount;
    write_entry(0, 8'h20);
    write_entry(1, 8'h20);
    volume = 3'd7; song_len = 7'd2; loop_en = 1'b0;
    do_start();
    watch(4100);
    checks++; if (pwm_a[4100] !== 1'b0 || idx_a[4100] !== 6'd1) begin errors++; $display("FAIL mid_pre: got pwm %b idx %0d expected 0 1", pwm_a[4100], idx_a[4100]); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pwm !== 1'b1) begin errors++; $display("FAIL mid_rst_pwm: got %b expected 1", pwm); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_rst_done: got %b expected 0", done); end
    checks++; if (note_idx !== '0) begin errors++; $display("FAIL mid_rst_idx: got %0d expected 0", note_idx); end
    @(negedge clk);
    rst_n = 1'b1;
    watch(20);
    bcount = 0;
    for (int c = 1; c <= 20; c++) if (busy_a[c] === 1'b1) bcount++;
    checks++; if (bcount != 0) begin errors++; $display("FAIL mid_no_resume: got %0d busy cycles expected 0", bcount); end
    song_len = 7'd1;
    do_start();
    watch(5);
    checks++; if (pwm_a[2] !== 1'b1 || pwm_a[3] !== 1'b0) begin errors++; $display("FAIL ram_retained: got %b%b expected 10", pwm_a[2], pwm_a[3]); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_note();
    test_octave_volume();
    test_rest();
    test_loop_stop();
    test_ignored_starts();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
